// File: rtl/mdu_pkg.sv
// Shared encodings and timing constants for the iterative multiply/divide unit.
package mdu_pkg;
    localparam int LATENCY = 33;           // start acceptance to done
    localparam int ITERS   = 32;           // radix-2 steps per operation
    localparam int CNT_W   = 5;            // iteration counter width

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    // Two's-complement magnitude when the value is treated as negative.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction
endpackage

// File: rtl/add_sub32.sv
// 33-bit adder/subtractor shared by the multiply and divide iterations.
// o_cout on a subtract is the "no borrow" flag (i_a >= i_b).
module add_sub32 (
    input  logic [32:0] i_a,
    input  logic [32:0] i_b,
    input  logic        i_sub,
    output logic [32:0] o_sum,
    output logic        o_cout
);
    logic [33:0] w_res;

    assign w_res  = {1'b0, i_a} + {1'b0, (i_sub ? ~i_b : i_b)} + {33'd0, i_sub};
    assign o_sum  = w_res[32:0];
    assign o_cout = w_res[33];
endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Works on operand magnitudes for 32 cycles, then fixes signs in one cycle.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int LATENCY = mdu_pkg::LATENCY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    // CALC spans LATENCY-1 cycles; FIX is the last one.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 2);

    state_e            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_op;
    logic              r_sa, r_sb;      // operand signs (0 for unsigned ops)
    logic [31:0]       r_acc;           // product high half / partial remainder
    logic [31:0]       r_q;             // multiplier->product low / dividend->quotient
    logic [31:0]       r_m;             // multiplicand or divisor magnitude
    logic [31:0]       r_hi, r_lo;
    logic              r_done;

    logic              w_accept, w_calc, w_fix, w_mtx_ok;
    logic              w_is_div;
    logic              w_sa_in, w_sb_in;
    logic [32:0]       w_add_a, w_add_b, w_sum;
    logic              w_cout;
    logic [63:0]       w_prod;
    logic [31:0]       w_quo, w_rem;

    assign w_is_div = r_op[1];
    assign w_sa_in  = op[0] & src_a[31];
    assign w_sb_in  = op[0] & src_b[31];

    // Multiply: acc + (lsb ? multiplicand : 0). Divide: {rem, next dividend bit} - divisor.
    assign w_add_a = w_is_div ? {r_acc, r_q[31]} : {1'b0, r_acc};
    assign w_add_b = (w_is_div || r_q[0]) ? {1'b0, r_m} : 33'd0;

    add_sub32 u_add_sub (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_sub  (w_is_div),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Sign correction; quotient and product take the XOR of the signs,
    // the remainder follows the dividend.
    assign w_prod = (r_sa ^ r_sb) ? (~{r_acc, r_q} + 64'd1) : {r_acc, r_q};
    assign w_quo  = mag32(r_q, r_sa ^ r_sb);
    assign w_rem  = mag32(r_acc, r_sa);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_calc      = 1'b0;
        w_fix       = 1'b0;
        w_mtx_ok    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_accept = start;
                w_mtx_ok = !start;          // start wins over MTHI/MTLO
                if (start) w_state_nxt = ST_CALC;
            end
            ST_CALC: begin
                w_calc = 1'b1;
                if (r_cnt == LAST_CNT) w_state_nxt = ST_FIX;
            end
            ST_FIX: begin
                w_fix       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture and one radix-2 step per CALC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_op   <= 2'b00;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_acc  <= '0;
            r_q    <= '0;
            r_m    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_fix;
            if (w_accept) begin
                r_op  <= op;
                r_sa  <= w_sa_in;
                r_sb  <= w_sb_in;
                r_cnt <= '0;
                r_acc <= '0;
                r_q   <= op[1] ? mag32(src_a, w_sa_in) : mag32(src_b, w_sb_in);
                r_m   <= op[1] ? mag32(src_b, w_sb_in) : mag32(src_a, w_sa_in);
            end else if (w_calc) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_is_div) begin
                    r_acc <= w_cout ? w_sum[31:0] : w_add_a[31:0];
                    r_q   <= {r_q[30:0], w_cout};
                end else begin
                    r_acc <= w_sum[32:1];
                    r_q   <= {w_sum[0], r_q[31:1]};
                end
            end
        end
    end

    // HI/LO: results land only in FIX; MTHI/MTLO only when idle and not starting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_fix) begin
            if (w_is_div) begin
                r_hi <= w_rem;
                r_lo <= (r_m == 32'd0) ? 32'hFFFF_FFFF : w_quo;
            end else begin
                r_hi <= w_prod[63:32];
                r_lo <= w_prod[31:0];
            end
        end else if (w_mtx_ok) begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: result table plus hand-written
// sequences for busy-time interference and mid-operation reset.
module tb_mult_div_unit;
    logic        clk, rst_n, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;
    logic [31:0] m_hi, m_lo;   // bench's own view of HI/LO

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, exp_hi, exp_lo;
        bit          disturb, wr_start;
    } vec_t;
    vec_t vecs[13];

    mult_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Launch one op, watch busy/hold/latency, then compare HI/LO.
    task automatic run_op(input string name, input vec_t v);
        int k, lat;
        bit seen, hold_ok, busy_ok;
        @(negedge clk);
        op = v.op; src_a = v.a; src_b = v.b; start = 1'b1;
        if (v.wr_start) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hBAD0_BAD0; end
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        k = 0; lat = 999; seen = 0; hold_ok = 1; busy_ok = 1;
        while (!seen && k <= 60) begin
            if (done) begin
                seen = 1; lat = k;
            end else begin
                if (!busy) busy_ok = 0;
                if (hi !== m_hi || lo !== m_lo) hold_ok = 0;
                if (v.disturb) begin
                    if (k == 10 || k == 20) begin
                        start = 1'b1; hi_we = 1'b1; wdata = 32'h0000_DEAD;
                        src_a = 32'h7777_7777; src_b = 32'h3; op = 2'b11;
                    end else begin
                        start = 1'b0; hi_we = 1'b0;
                    end
                end
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check({name, " latency"}, lat, 33);
        check({name, " busy_during"}, {31'd0, busy_ok}, 1);
        check({name, " hold_hilo"}, {31'd0, hold_ok}, 1);
        check({name, " hi"}, hi, v.exp_hi);
        check({name, " lo"}, lo, v.exp_lo);
        check({name, " busy_at_done"}, {31'd0, busy}, 0);
        @(negedge clk);
        check({name, " done_pulse"}, {31'd0, done}, 0);
        m_hi = v.exp_hi; m_lo = v.exp_lo;
    endtask

    initial begin
        int npulse;
        vec_t rv;
        //          op     a             b             hi            lo            dist wr
        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 1};
        vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0};
        vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0};
        vecs[3]  = '{2'b10, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 0, 0};
        vecs[4]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 0};
        vecs[5]  = '{2'b00, 32'h00000005, 32'h00000006, 32'h00000000, 32'h0000001E, 1, 0};
        vecs[6]  = '{2'b10, 32'h000003E8, 32'h00000003, 32'h00000001, 32'h0000014D, 0, 0};
        vecs[7]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 0};
        vecs[8]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0, 0};
        vecs[9]  = '{2'b11, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 0, 0};
        vecs[10] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 0};
        vecs[11] = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 0, 0};
        vecs[12] = '{2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 0, 0};

        rst_n = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; src_a = '0; src_b = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 0);
        check("reset done", {31'd0, done}, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        rst_n = 1'b1;

        // MTHI+MTLO in the same cycle, then MTHI alone.
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_5A5A;
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b0; wdata = 32'h1111_2222;
        check("mthi_mtlo hi", hi, 32'hA5A5_5A5A);
        check("mthi_mtlo lo", lo, 32'hA5A5_5A5A);
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_only hi", hi, 32'h1111_2222);
        check("mthi_only lo", lo, 32'hA5A5_5A5A);
        m_hi = 32'h1111_2222; m_lo = 32'hA5A5_5A5A;

        for (int i = 0; i < 13; i++) run_op($sformatf("vec%0d", i), vecs[i]);

        // Reset at cycle 15 of DIVU 1000/3: aborts with no done, then MTLO.
        @(negedge clk);
        op = 2'b10; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset busy", {31'd0, busy}, 0);
        check("midreset hi", hi, 0);
        check("midreset lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        lo_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        lo_we = 1'b0;
        npulse = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) npulse++;
            @(negedge clk);
        end
        check("midreset no_done", npulse, 0);
        check("midreset mtlo hi", hi, 0);
        check("midreset mtlo lo", lo, 32'h0000_1234);
        m_hi = 32'h0; m_lo = 32'h0000_1234;
        rv = '{2'b10, 32'd1000, 32'd3, 32'd1, 32'd333, 0, 0};
        run_op("after_reset", rv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
